// File: rtl/sensor_event_arbiter_pkg.sv
// Shared definitions for the sensor event arbiter: FSM states, sensor indices, width helpers.
package sensor_event_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } arb_state_t;

    localparam int SNS_LIGHT = 0;
    localparam int SNS_SOUND = 1;
    localparam int SNS_PROX  = 2;
    localparam int SNS_BTN   = 3;

    // Bits needed to hold 0..max_val; never less than one so COOLDOWN=0 still builds.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    // Bits needed to index n entries.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sensor_rr_pick.sv
// Combinational winner select over the pending flags.
// FIXED_PRIO_EN defined: lowest index wins; otherwise round robin starting at i_rr_ptr.
module sensor_rr_pick
    import sensor_event_arbiter_pkg::*;
#(
    parameter int N_SENSORS = 4,
    parameter int IDX_W     = 2
) (
    input  logic [N_SENSORS-1:0] i_pending,
    input  logic [IDX_W-1:0]     i_rr_ptr,
    output logic [IDX_W-1:0]     o_winner,
    output logic                 o_any
);

    logic w_found;

    always_comb begin
        o_winner = '0;
        o_any    = |i_pending;
        w_found  = 1'b0;
`ifdef FIXED_PRIO_EN
        for (int i = N_SENSORS - 1; i >= 0; i--) begin
            if (i_pending[i]) o_winner = IDX_W'(i);
        end
`else
        for (int off = 0; off < N_SENSORS; off++) begin
            int idx;
            idx = int'(i_rr_ptr) + off;
            if (idx >= N_SENSORS) idx = idx - N_SENSORS;
            if (!w_found && i_pending[idx]) begin
                o_winner = IDX_W'(idx);
                w_found  = 1'b1;
            end
        end
`endif
    end

endmodule

// File: rtl/sensor_event_arbiter.sv
// Captures falling edges of active-low sensors into pending flags and serialises them
// onto a valid/ready channel with per-sensor cooldown. FIXED_PRIO_EN selects fixed priority.
module sensor_event_arbiter
    import sensor_event_arbiter_pkg::*;
#(
    parameter int N_SENSORS = 4,
    parameter int COOLDOWN  = 50,
    localparam int IDX_W    = idx_w(N_SENSORS),
    localparam int CD_W     = cnt_w(COOLDOWN)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_SENSORS-1:0] sensor_n,
    input  logic                 enable,
    output logic                 evt_valid,
    output logic [IDX_W-1:0]     evt_id,
    input  logic                 evt_ready,
    output logic [N_SENSORS-1:0] pending,
    output logic                 overrun
);

    arb_state_t             r_state;
    logic [N_SENSORS-1:0]   r_sensor_q;
    logic [IDX_W-1:0]       r_rr_ptr;
    logic [CD_W-1:0]        r_cd [N_SENSORS];

    logic [N_SENSORS-1:0]   w_fall;
    logic [N_SENSORS-1:0]   w_cd_zero;
    logic [N_SENSORS-1:0]   w_acc_vec;
    logic [N_SENSORS-1:0]   w_cap;
    logic                   w_acc;
    logic [IDX_W-1:0]       w_winner;
    logic                   w_any;

    assign w_fall = r_sensor_q & ~sensor_n;
    assign w_acc  = evt_valid & evt_ready;

    always_comb begin
        w_acc_vec = '0;
        if (w_acc) w_acc_vec[evt_id] = 1'b1;
    end

    // An edge on the sensor being accepted this cycle is dropped, not merged.
    assign w_cap = w_fall & {N_SENSORS{enable}} & w_cd_zero & ~w_acc_vec;

    for (genvar g = 0; g < N_SENSORS; g++) begin : g_cd
        assign w_cd_zero[g] = (r_cd[g] == '0);

        always_ff @(posedge clk) begin
            if (!reset)
                r_cd[g] <= '0;
            else if (w_acc_vec[g])
                r_cd[g] <= CD_W'(COOLDOWN);
            else if (!w_cd_zero[g])
                r_cd[g] <= r_cd[g] - CD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sensor_q <= '1;
            pending    <= '0;
            overrun    <= 1'b0;
        end else begin
            r_sensor_q <= sensor_n;
            pending    <= (pending & ~w_acc_vec) | w_cap;
            overrun    <= |(w_cap & pending & ~w_acc_vec);
        end
    end

    sensor_rr_pick #(
        .N_SENSORS (N_SENSORS),
        .IDX_W     (IDX_W)
    ) u_pick (
        .i_pending (pending),
        .i_rr_ptr  (r_rr_ptr),
        .o_winner  (w_winner),
        .o_any     (w_any)
    );

    // Offer stays frozen in ST_OFFER until the consumer takes it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            evt_valid <= 1'b0;
            evt_id    <= '0;
            r_rr_ptr  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        evt_id    <= w_winner;
                        evt_valid <= 1'b1;
                        r_state   <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (evt_ready) begin
                        evt_valid <= 1'b0;
                        r_state   <= ST_IDLE;
`ifndef FIXED_PRIO_EN
                        r_rr_ptr  <= (evt_id == IDX_W'(N_SENSORS - 1)) ? '0 : evt_id + IDX_W'(1);
`endif
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
